// File: rtl/pulse_stretcher_pkg.sv
// Shared constants and lane-state decoding for the pulse stretcher.
// Contents:
//   WIDTH_DEF, LEN_W_DEF : default lane count and stretch-length width.
//   lane_st_e            : decoded lane state (IDLE / LAST / ACTIVE).
//   lane_state()         : maps a lane counter value onto lane_st_e.
package pulse_stretcher_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAST   = 2'd1,
    ACTIVE = 2'd2
  } lane_st_e;

  // Callers zero-extend their counter to 32 bits, so one function serves every LEN_W.
  function automatic lane_st_e lane_state(input logic [31:0] cnt);
    if (cnt == 32'd0) begin
      return IDLE;
    end else if (cnt == 32'd1) begin
      return LAST;
    end else begin
      return ACTIVE;
    end
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between the pulse producer and the stretcher.
// Signals:
//   in      : per-lane trigger pulses
//   len     : stretch length minus one, shared by all lanes
//   retrig  : 1 = trigger while busy reloads, 0 = trigger while busy is dropped
//   ovf_clr : clears all sticky overflow bits
//   out     : stretched level per lane
//   busy    : OR of out
//   ovf     : sticky per-lane dropped-trigger flag
// Modports: master drives triggers/config, slave (the stretcher) drives levels/flags.
interface pulse_stretcher_if
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic [WIDTH-1:0] in;
  logic [LEN_W-1:0] len;
  logic             retrig;
  logic             ovf_clr;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic [WIDTH-1:0] ovf;

  modport master (
    output in, len, retrig, ovf_clr,
    input  out, busy, ovf
  );

  modport slave (
    input  in, len, retrig, ovf_clr,
    output out, busy, ovf
  );

endinterface

// File: rtl/pulse_stretcher_lane.sv
// One stretcher lane: reload counter, accept/drop decision and sticky overflow bit.
// Ports:
//   clk, arstn : clock, asynchronous active-low reset
//   trig       : trigger pulse for this lane
//   len        : stretch length minus one (sampled only when a trigger is accepted)
//   retrig     : reload on trigger while ACTIVE when 1, drop it when 0
//   ovf_clr    : clear the overflow bit (a same-cycle drop wins)
//   out        : stretched level, straight from the counter register
//   ovf        : sticky dropped-trigger flag
module pulse_stretch_lane
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             trig,
  input  logic [LEN_W-1:0] len,
  input  logic             retrig,
  input  logic             ovf_clr,
  output logic             out,
  output logic             ovf
);

  // One bit wider than len so len = all-ones loads 2**LEN_W without wrapping.
  localparam int unsigned CW = LEN_W + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] load;
  logic          ovf_nxt;
  logic          dropped;

  assign load = CW'(len) + CW'(1);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    dropped = 1'b0;
    case (lane_state(32'(cnt)))
      IDLE: begin
        if (trig) cnt_nxt = load;
      end
      // Reloading in the final cycle chains stretches with no low gap.
      LAST: begin
        cnt_nxt = trig ? load : '0;
      end
      ACTIVE: begin
        if (trig && retrig) begin
          cnt_nxt = load;
        end else begin
          cnt_nxt = cnt - CW'(1);
          dropped = trig;
        end
      end
      default: cnt_nxt = '0;
    endcase

    ovf_nxt = ovf;
    if (dropped) begin
      ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end
  end

  assign out = (cnt != '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Per-lane pulse stretcher: turns single-cycle pulses on each lane into a level
// lasting len+1 cycles, with optional retriggering and sticky overflow flags.
// Ports:
//   clk   : single rising-edge clock
//   arstn : asynchronous active-low reset
//   bus   : pulse_stretcher_if.slave (in, len, retrig, ovf_clr -> out, busy, ovf)
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              arstn,
  pulse_stretcher_if.slave  bus
);

  logic [WIDTH-1:0] out_w;
  logic [WIDTH-1:0] ovf_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pulse_stretch_lane #(
      .LEN_W (LEN_W)
    ) u_lane (
      .clk     (clk),
      .arstn   (arstn),
      .trig    (bus.in[i]),
      .len     (bus.len),
      .retrig  (bus.retrig),
      .ovf_clr (bus.ovf_clr),
      .out     (out_w[i]),
      .ovf     (ovf_w[i])
    );
  end

  assign bus.out  = out_w;
  assign bus.ovf  = ovf_w;
  assign bus.busy = |out_w;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;
  import pulse_stretcher_pkg::*;

  localparam int unsigned W  = WIDTH_DEF;
  localparam int unsigned LW = LEN_W_DEF;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  pulse_stretcher #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string          name;
    logic [W-1:0]   in;
    logic [LW-1:0]  len;
    logic           retrig;
    logic           clr;
    logic [W-1:0]   e_out;
    logic           e_busy;
    logic [W-1:0]   e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] i, input logic [LW-1:0] l,
                       input logic r, input logic c);
    bus.in      = i;
    bus.len     = l;
    bus.retrig  = r;
    bus.ovf_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [W-1:0] eo,
                           input logic eb, input logic [W-1:0] ev);
    check({name, ".out"},  32'(bus.out),  32'(eo));
    check({name, ".busy"}, 32'(bus.busy), 32'(eb));
    check({name, ".ovf"},  32'(bus.ovf),  32'(ev));
  endtask

  function automatic void add(input string n, input logic [W-1:0] i, input logic [LW-1:0] l,
                              input logic r, input logic c, input logic [W-1:0] eo,
                              input logic [W-1:0] ev);
    vec_t v;
    v.name = n; v.in = i; v.len = l; v.retrig = r; v.clr = c;
    v.e_out = eo; v.e_busy = (eo != '0); v.e_ovf = ev;
    vecs.push_back(v);
  endfunction

  // Reference model: each lane remembers the edge index at which its level ends.
  longint        n_edge;
  longint        end_at [W];
  logic [W-1:0]  m_ovf;

  task automatic model_reset();
    n_edge = 0;
    m_ovf  = '0;
    for (int i = 0; i < int'(W); i++) end_at[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] i_in, input logic [LW-1:0] l,
                            input logic r, input logic c);
    for (int i = 0; i < int'(W); i++) begin
      logic drop;
      drop = 1'b0;
      if (i_in[i]) begin
        // Idle or in its final high cycle (end_at <= now) always accepts.
        if (end_at[i] <= n_edge || r) end_at[i] = n_edge + longint'(l) + 1;
        else drop = 1'b1;
      end
      if (drop) m_ovf[i] = 1'b1;
      else if (c) m_ovf[i] = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] o;
    for (int i = 0; i < int'(W); i++) o[i] = (n_edge < end_at[i]);
    return o;
  endfunction

  initial begin
    int hi;
    logic [W-1:0] r_in;
    logic [LW-1:0] r_len;
    logic r_rt, r_clr, r_busy_exp;
    logic [W-1:0] r_out_exp;

    // 1: reset held 30ns
    arstn = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) begin
      #9;
      check_all("reset_hold", '0, 1'b0, '0);
    end
    #3 arstn = 1'b1;
    repeat (3) begin
      tick();
      check_all("post_reset_idle", '0, 1'b0, '0);
    end

    // 2..5 directed vectors
    add("t2_single", 8'h02, 4'd3, 1'b0, 1'b0, 8'h02, 8'h00);
    add("t2_hold1",  8'h00, 4'd3, 1'b0, 1'b0, 8'h02, 8'h00);
    add("t2_hold2",  8'h00, 4'd3, 1'b0, 1'b0, 8'h02, 8'h00);
    add("t2_hold3",  8'h00, 4'd3, 1'b0, 1'b0, 8'h02, 8'h00);
    add("t2_end",    8'h00, 4'd3, 1'b0, 1'b0, 8'h00, 8'h00);
    add("t3_first",  8'h02, 4'd3, 1'b1, 1'b0, 8'h02, 8'h00);
    add("t3_gap",    8'h00, 4'd3, 1'b1, 1'b0, 8'h02, 8'h00);
    add("t3_retrig", 8'h02, 4'd3, 1'b1, 1'b0, 8'h02, 8'h00);
    add("t3_h1",     8'h00, 4'd3, 1'b1, 1'b0, 8'h02, 8'h00);
    add("t3_h2",     8'h00, 4'd3, 1'b1, 1'b0, 8'h02, 8'h00);
    add("t3_h3",     8'h00, 4'd3, 1'b1, 1'b0, 8'h02, 8'h00);
    add("t3_end",    8'h00, 4'd3, 1'b1, 1'b0, 8'h00, 8'h00);
    add("t4_first",  8'h02, 4'd3, 1'b0, 1'b0, 8'h02, 8'h00);
    add("t4_gap",    8'h00, 4'd3, 1'b0, 1'b0, 8'h02, 8'h00);
    add("t4_drop",   8'h02, 4'd3, 1'b0, 1'b0, 8'h02, 8'h02);
    add("t4_h",      8'h00, 4'd3, 1'b0, 1'b0, 8'h02, 8'h02);
    add("t4_end",    8'h00, 4'd3, 1'b0, 1'b0, 8'h00, 8'h02);
    add("t4_clr",    8'h00, 4'd3, 1'b0, 1'b1, 8'h00, 8'h00);
    add("t4_after",  8'h00, 4'd3, 1'b0, 1'b0, 8'h00, 8'h00);
    add("t5_first",  8'h08, 4'd2, 1'b0, 1'b0, 8'h08, 8'h00);
    add("t5_h1",     8'h00, 4'd2, 1'b0, 1'b0, 8'h08, 8'h00);
    add("t5_h2",     8'h00, 4'd2, 1'b0, 1'b0, 8'h08, 8'h00);
    add("t5_chain",  8'h08, 4'd2, 1'b0, 1'b0, 8'h08, 8'h00);
    add("t5_c1",     8'h00, 4'd2, 1'b0, 1'b0, 8'h08, 8'h00);
    add("t5_c2",     8'h00, 4'd2, 1'b0, 1'b0, 8'h08, 8'h00);
    add("t5_end",    8'h00, 4'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    add("t5_multi",  8'h0E, 4'd2, 1'b0, 1'b0, 8'h0E, 8'h00);
    add("t5_m1",     8'h00, 4'd2, 1'b0, 1'b0, 8'h0E, 8'h00);
    add("t5_m2",     8'h00, 4'd2, 1'b0, 1'b0, 8'h0E, 8'h00);
    add("t5_mend",   8'h00, 4'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    add("sat_ovf_clr_prio", 8'hC0, 4'd4, 1'b0, 1'b0, 8'hC0, 8'h00);
    add("sat_drop_vs_clr",  8'h40, 4'd4, 1'b0, 1'b1, 8'hC0, 8'h40);

    foreach (vecs[k]) begin
      drive(vecs[k].in, vecs[k].len, vecs[k].retrig, vecs[k].clr);
      tick();
      check_all(vecs[k].name, vecs[k].e_out, vecs[k].e_busy, vecs[k].e_ovf);
    end
    drive('0, '0, 1'b0, 1'b1);
    repeat (6) tick();
    check_all("drain", '0, 1'b0, '0);

    // 6: async reset mid-stretch, then maximum length
    drive(8'hFF, 4'd5, 1'b0, 1'b0);
    tick();
    check_all("t6_all_on", 8'hFF, 1'b1, 8'h00);
    tick();
    check_all("t6_all_drop", 8'hFF, 1'b1, 8'hFF);
    drive('0, 4'd5, 1'b0, 1'b0);
    tick();
    #2 arstn = 1'b0;
    #1;
    check_all("t6_async_kill", '0, 1'b0, '0);
    #3 arstn = 1'b1;
    drive(8'h01, 4'd15, 1'b0, 1'b0);
    tick();
    hi = bus.out[0] ? 1 : 0;
    drive('0, 4'd15, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out[0]) hi++;
    end
    check("t6_len15_cycles", 32'(hi), 32'd16);
    check_all("t6_len15_done", '0, 1'b0, '0);

    // Randomized run against the end-time model
    arstn = 1'b0;
    #2 arstn = 1'b1;
    model_reset();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < int'(W); b++) r_in[b] = ($urandom_range(0, 5) == 0);
      r_len = ($urandom_range(0, 1) == 0) ? LW'($urandom_range(0, 3)) : LW'($urandom_range(0, 15));
      r_rt  = 1'($urandom_range(0, 1));
      r_clr = ($urandom_range(0, 15) == 0);
      drive(r_in, r_len, r_rt, r_clr);
      tick();
      model_edge(r_in, r_len, r_rt, r_clr);
      r_out_exp  = model_out();
      r_busy_exp = (r_out_exp != '0);
      check_all("rand", r_out_exp, r_busy_exp, m_ovf);
      n_edge++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
